// File: rtl/hack_pkg.sv
// Shared Hack platform constants and the program loader state encoding.
// LOAD_MAX_WORDS is also the depth of the instruction ROM.
package hack_pkg;

  localparam int HACK_ADDR_W    = 15;
  localparam int HACK_WORD_W    = 16;
  localparam int LOAD_MAX_WORDS = 32768;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_RUN,
    ST_ERROR
  } load_state_t;

endpackage

// File: rtl/hack_byte_pair.sv
// Assembles a big-endian 2-byte field: the high byte is held, the low byte
// passes straight through so the full value is usable in the accepting cycle.
module hack_byte_pair (
  input  logic        clock,
  input  logic        reset,
  input  logic        hi_take,
  input  logic        lo_take,
  input  logic [7:0]  data,
  output logic [15:0] value,
  output logic        valid
);

  logic [7:0] hi_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q <= '0;
    end else if (hi_take) begin
      hi_q <= data;
    end
  end

  assign value = {hi_q, data};
  assign valid = lo_take;

endmodule

// File: rtl/hack_rom_loader.sv
// Loads a length-prefixed byte stream into the Hack instruction ROM while
// holding the CPU in reset; releases it once the whole image is written.
//
//   state      | meaning
//   -----------+----------------------------------------------
//   ST_IDLE    | waiting for the first start after reset
//   ST_LEN_HI  | expecting length high byte
//   ST_LEN_LO  | expecting length low byte, then validate N
//   ST_DATA_HI | expecting high byte of the next word
//   ST_DATA_LO | expecting low byte; word is written next cycle
//   ST_RUN     | image loaded, CPU released (done)
//   ST_ERROR   | length rejected (error)
module hack_rom_loader
  import hack_pkg::*;
#(
  parameter int ADDR_W    = HACK_ADDR_W,
  parameter int WORD_W    = HACK_WORD_W,
  parameter int MAX_WORDS = LOAD_MAX_WORDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  load_state_t state, state_next;

  logic          accept;
  logic [15:0]   len_value, word_value, len_q;
  logic          len_valid, word_valid;
  logic [ADDR_W:0] count;
  logic          last_word, len_zero, len_over;

  assign in_ready = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                    (state == ST_DATA_HI) || (state == ST_DATA_LO);
  // start takes priority: a byte offered alongside it is dropped
  assign accept   = in_valid && in_ready && !start;

  hack_byte_pair u_len (
    .clock   (clock),
    .reset   (reset),
    .hi_take (accept && (state == ST_LEN_HI)),
    .lo_take (accept && (state == ST_LEN_LO)),
    .data    (in_data),
    .value   (len_value),
    .valid   (len_valid)
  );

  hack_byte_pair u_word (
    .clock   (clock),
    .reset   (reset),
    .hi_take (accept && (state == ST_DATA_HI)),
    .lo_take (accept && (state == ST_DATA_LO)),
    .data    (in_data),
    .value   (word_value),
    .valid   (word_valid)
  );

  assign len_zero  = (len_value == 16'd0);
  assign len_over  = 32'(len_value) > 32'(MAX_WORDS);
  assign last_word = (32'(count) + 32'd1) == 32'(len_q);

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ST_LEN_HI;
    end else begin
      case (state)
        ST_LEN_HI:  if (accept) state_next = ST_LEN_LO;
        ST_LEN_LO: begin
          if (len_valid) begin
            if (len_zero)      state_next = ST_RUN;
            else if (len_over) state_next = ST_ERROR;
            else               state_next = ST_DATA_HI;
          end
        end
        ST_DATA_HI: if (accept) state_next = ST_DATA_LO;
        ST_DATA_LO: if (word_valid) state_next = last_word ? ST_RUN : ST_DATA_HI;
        default:    state_next = state;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      count     <= '0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
    end else begin
      state  <= state_next;
      rom_we <= word_valid;
      if (len_valid) len_q <= len_value;
      if (start) begin
        count <= '0;
      end else if (word_valid) begin
        rom_addr  <= count[ADDR_W-1:0];
        rom_wdata <= WORD_W'(word_value);
        count     <= count + 1'b1;
      end
    end
  end

  // the final write lands in the first RUN cycle; keep the CPU held through it
  assign cpu_reset = (state != ST_RUN) || rom_we;
  assign busy      = in_ready;
  assign done      = (state == ST_RUN);
  assign error     = (state == ST_ERROR);

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader: one task per scenario, inline checks.
module tb_hack_rom_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, rom_we, cpu_reset, busy, done, error;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;

  int checks = 0;
  int fails  = 0;

  logic [14:0] wr_addr[$];
  logic [15:0] wr_data[$];

  hack_rom_loader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rom_we === 1'b1) begin
      wr_addr.push_back(rom_addr);
      wr_data.push_back(rom_wdata);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      in_valid = 1'b0;
      wait_cycles(gap);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 20) begin
      checks++; fails++;
      $display("FAIL send_byte_timeout byte %h: in_ready %b, want 1", b, in_ready);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(3);
    checks++; if (in_ready  !== 1'b0)  begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (rom_we    !== 1'b0)  begin fails++; $display("FAIL reset_rom_we got %b want 0", rom_we); end
    checks++; if (rom_addr  !== 15'd0) begin fails++; $display("FAIL reset_rom_addr got %h want 0", rom_addr); end
    checks++; if (rom_wdata !== 16'd0) begin fails++; $display("FAIL reset_rom_wdata got %h want 0", rom_wdata); end
    checks++; if (cpu_reset !== 1'b1)  begin fails++; $display("FAIL reset_cpu_reset got %b want 1", cpu_reset); end
    checks++; if (busy      !== 1'b0)  begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done      !== 1'b0)  begin fails++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (error     !== 1'b0)  begin fails++; $display("FAIL reset_error got %b want 0", error); end
    reset = 1'b0;
    wait_cycles(1);
  endtask

  task automatic test_basic();
    clear_log();
    pulse_start();
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_after_start got %b want 1", busy); end
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'hEC, 0); send_byte(8'h10, 0);
    send_byte(8'h00, 0); send_byte(8'h07, 0);
    // first cycle after the final low byte: second write, CPU still held
    checks++; if (rom_we    !== 1'b1)     begin fails++; $display("FAIL basic_last_we got %b want 1", rom_we); end
    checks++; if (rom_addr  !== 15'd1)    begin fails++; $display("FAIL basic_last_addr got %h want 1", rom_addr); end
    checks++; if (rom_wdata !== 16'h0007) begin fails++; $display("FAIL basic_last_wdata got %h want 0007", rom_wdata); end
    checks++; if (cpu_reset !== 1'b1)     begin fails++; $display("FAIL basic_cpu_reset_during_we got %b want 1", cpu_reset); end
    in_valid = 1'b0;
    wait_cycles(1);
    checks++; if (rom_we    !== 1'b0) begin fails++; $display("FAIL basic_we_after got %b want 0", rom_we); end
    checks++; if (cpu_reset !== 1'b0) begin fails++; $display("FAIL basic_cpu_reset_fall got %b want 0", cpu_reset); end
    checks++; if (done      !== 1'b1) begin fails++; $display("FAIL basic_done got %b want 1", done); end
    checks++; if (busy      !== 1'b0) begin fails++; $display("FAIL basic_busy got %b want 0", busy); end
    wait_cycles(2);
    checks++; if (wr_addr.size() !== 2) begin fails++; $display("FAIL basic_write_count got %0d want 2", wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      checks++; if (wr_addr[0] !== 15'd0 || wr_data[0] !== 16'hEC10) begin fails++; $display("FAIL basic_write0 got %h/%h want 0000/ec10", wr_addr[0], wr_data[0]); end
      checks++; if (wr_addr[1] !== 15'd1 || wr_data[1] !== 16'h0007) begin fails++; $display("FAIL basic_write1 got %h/%h want 0001/0007", wr_addr[1], wr_data[1]); end
    end
  endtask

  task automatic test_gapped();
    clear_log();
    pulse_start();
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL gapped_done_cleared got %b want 0", done); end
    send_byte(8'h00, 2); send_byte(8'h02, 2);
    send_byte(8'hEC, 2); send_byte(8'h10, 2);
    send_byte(8'h00, 2); send_byte(8'h07, 2);
    in_valid = 1'b0;
    wait_cycles(4);
    checks++; if (wr_addr.size() !== 2) begin fails++; $display("FAIL gapped_write_count got %0d want 2", wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      checks++; if (wr_addr[0] !== 15'd0 || wr_data[0] !== 16'hEC10) begin fails++; $display("FAIL gapped_write0 got %h/%h want 0000/ec10", wr_addr[0], wr_data[0]); end
      checks++; if (wr_addr[1] !== 15'd1 || wr_data[1] !== 16'h0007) begin fails++; $display("FAIL gapped_write1 got %h/%h want 0001/0007", wr_addr[1], wr_data[1]); end
    end
    checks++; if (done !== 1'b1 || cpu_reset !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL gapped_final got done %b cpu_reset %b busy %b want 1 0 0", done, cpu_reset, busy); end
  endtask

  task automatic test_zero_len();
    clear_log();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    checks++; if (cpu_reset !== 1'b0) begin fails++; $display("FAIL zero_cpu_reset got %b want 0", cpu_reset); end
    checks++; if (done      !== 1'b1) begin fails++; $display("FAIL zero_done got %b want 1", done); end
    checks++; if (in_ready  !== 1'b0) begin fails++; $display("FAIL zero_in_ready got %b want 0", in_ready); end
    in_valid = 1'b0;
    wait_cycles(3);
    checks++; if (wr_addr.size() !== 0) begin fails++; $display("FAIL zero_write_count got %0d want 0", wr_addr.size()); end
  endtask

  task automatic test_too_long();
    clear_log();
    pulse_start();
    send_byte(8'h80, 0); send_byte(8'h01, 0);
    in_valid = 1'b0;
    checks++; if (error     !== 1'b1) begin fails++; $display("FAIL long_error got %b want 1", error); end
    checks++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL long_cpu_reset got %b want 1", cpu_reset); end
    checks++; if (in_ready  !== 1'b0) begin fails++; $display("FAIL long_in_ready got %b want 0", in_ready); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL long_done_busy got %b %b want 0 0", done, busy); end
    wait_cycles(3);
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL long_error_sticky got %b want 1", error); end
    checks++; if (wr_addr.size() !== 0) begin fails++; $display("FAIL long_write_count got %0d want 0", wr_addr.size()); end
    pulse_start();
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL long_error_cleared got %b want 0", error); end
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    in_valid = 1'b0;
    wait_cycles(3);
    checks++; if (wr_addr.size() !== 1) begin fails++; $display("FAIL recover_write_count got %0d want 1", wr_addr.size()); end
    if (wr_addr.size() == 1) begin
      checks++; if (wr_addr[0] !== 15'd0 || wr_data[0] !== 16'h1234) begin fails++; $display("FAIL recover_write0 got %h/%h want 0000/1234", wr_addr[0], wr_data[0]); end
    end
    checks++; if (done !== 1'b1 || error !== 1'b0 || cpu_reset !== 1'b0) begin fails++; $display("FAIL recover_final got done %b error %b cpu_reset %b want 1 0 0", done, error, cpu_reset); end
  endtask

  task automatic test_max_len();
    pulse_start();
    send_byte(8'h80, 0); send_byte(8'h00, 0);
    in_valid = 1'b0;
    checks++; if (error    !== 1'b0) begin fails++; $display("FAIL max_len_error got %b want 0", error); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL max_len_accepting got in_ready %b busy %b want 1 1", in_ready, busy); end
  endtask

  task automatic test_restart();
    clear_log();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_byte(8'h11, 0); send_byte(8'h11, 0);
    in_valid = 1'b0;
    wait_cycles(2);
    // restart with a byte offered in the same cycle; it must be dropped
    start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    @(posedge clock); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL restart_state got busy %b done %b want 1 0", busy, done); end
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h22, 0); send_byte(8'h22, 0);
    send_byte(8'h33, 0); send_byte(8'h33, 0);
    in_valid = 1'b0;
    wait_cycles(3);
    checks++; if (wr_addr.size() !== 3) begin fails++; $display("FAIL restart_write_count got %0d want 3", wr_addr.size()); end
    if (wr_addr.size() == 3) begin
      checks++; if (wr_addr[0] !== 15'd0 || wr_data[0] !== 16'h1111) begin fails++; $display("FAIL restart_write0 got %h/%h want 0000/1111", wr_addr[0], wr_data[0]); end
      checks++; if (wr_addr[1] !== 15'd0 || wr_data[1] !== 16'h2222) begin fails++; $display("FAIL restart_write1 got %h/%h want 0000/2222", wr_addr[1], wr_data[1]); end
      checks++; if (wr_addr[2] !== 15'd1 || wr_data[2] !== 16'h3333) begin fails++; $display("FAIL restart_write2 got %h/%h want 0001/3333", wr_addr[2], wr_data[2]); end
    end
    checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin fails++; $display("FAIL restart_final got done %b cpu_reset %b want 1 0", done, cpu_reset); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h55, 0);
    in_data = 8'h66;
    reset   = 1'b1;
    @(posedge clock); #1;
    checks++; if (in_ready  !== 1'b0)  begin fails++; $display("FAIL mid_reset_in_ready got %b want 0", in_ready); end
    checks++; if (rom_we    !== 1'b0)  begin fails++; $display("FAIL mid_reset_rom_we got %b want 0", rom_we); end
    checks++; if (rom_addr  !== 15'd0) begin fails++; $display("FAIL mid_reset_rom_addr got %h want 0", rom_addr); end
    checks++; if (rom_wdata !== 16'd0) begin fails++; $display("FAIL mid_reset_rom_wdata got %h want 0", rom_wdata); end
    checks++; if (cpu_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL mid_reset_flags got cpu_reset %b busy %b done %b error %b want 1 0 0 0", cpu_reset, busy, done, error); end
    reset    = 1'b0;
    in_valid = 1'b0;
    wait_cycles(3);
    checks++; if (wr_addr.size() !== 0) begin fails++; $display("FAIL mid_reset_write_count got %0d want 0", wr_addr.size()); end
    checks++; if (busy !== 1'b0 || cpu_reset !== 1'b1) begin fails++; $display("FAIL mid_reset_idle got busy %b cpu_reset %b want 0 1", busy, cpu_reset); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_zero_len();
    test_too_long();
    test_max_len();
    test_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
- Program loader sitting directly upstream of the Hack Computer.
- Receives a byte stream (from the UART receiver) and assembles it into 16-bit instruction words.
- Writes those words into the instruction ROM write port, holding the CPU in reset for the whole load.
- Releases the CPU reset once the full image has been written, so the Computer starts executing at address 0.

Parameters:
- ADDR_W, 15, ROM address width (ROM32K).
- WORD_W, 16, instruction word width.
- MAX_WORDS, 32768, largest legal image length in words.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle pulse, begins or restarts a load
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- rom_we  out  1  ROM write strobe, one cycle per word
- rom_addr  out  ADDR_W  ROM write address
- rom_wdata  out  WORD_W  ROM write data
- cpu_reset  out  1  drives the Computer's reset input
- busy  out  1  load in progress
- done  out  1  last load completed successfully (sticky)
- error  out  1  last load rejected (sticky)

Behaviour:
- Handshake: a byte transfers on a clock edge where in_valid && in_ready. in_ready is a pure function of state: 1 in LEN_HI, LEN_LO, DATA_HI and DATA_LO, 0 otherwise.
- Stream format, all fields big-endian:
  - 2-byte length N (words).
  - Then N words, each as 2 bytes (high byte, then low byte).
- States and transitions:
  - IDLE: on start -> LEN_HI.
  - LEN_HI: on accept, latch N[15:8] -> LEN_LO.
  - LEN_LO: on accept, latch N[7:0], then:
    - N==0 -> RUN.
    - N>MAX_WORDS -> ERROR.
    - otherwise -> DATA_HI.
  - DATA_HI: on accept, latch high byte -> DATA_LO.
  - DATA_LO: on accept, register word and address. Next cycle rom_we=1 with rom_addr=word count, rom_wdata={hi,lo}, and the count increments. If this was word N -> RUN, else -> DATA_HI.
  - RUN: cpu_reset=0, done=1. On start -> LEN_HI.
  - ERROR: error=1. On start -> LEN_HI.
- Write timing: rom_we is registered, one cycle after the low byte is accepted. DATA_HI may accept the next byte in that same cycle, so sustained throughput is 1 byte per cycle.
- cpu_reset:
  - 1 in every state except RUN.
  - Goes low the cycle after the final rom_we (never coincident with a write).
- busy: 1 in states LEN_HI through DATA_LO.
- done and error: set as above; both cleared on start or reset.
- start in any state, including mid-load: counters cleared, -> LEN_HI, done=error=0, cpu_reset=1. Already-written ROM words remain in place and are overwritten by the new image.
- start coincident with an accepted byte: start wins and the byte is discarded.
- Address wrap: none possible. N<=MAX_WORDS, and the counter is ADDR_W+1 bits wide.
- Reset values, in any state including mid-load: state IDLE, in_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, cpu_reset=1, busy=0, done=0, error=0. ROM contents are not touched.

Decomposition:
- Shared package hack_pkg holds:
  - Loader state enum.
  - HACK_ADDR_W=15 and HACK_WORD_W=16 constants.
  - LOAD_MAX_WORDS constant, also used by the ROM.
- Sub-module: hack_byte_pair, which assembles big-endian 2-byte fields into a 16-bit value with a valid pulse. It is reused for both the length field and the data words. Everything else stays in the single FSM module.

Test Plan:
- Reset then start, stream 00 02 EC 10 00 07 with in_valid held high:
  - rom_we pulses twice: addr 0 / 0xEC10, then addr 1 / 0x0007.
  - cpu_reset falls 1 cycle after the second write; done=1; busy=0.
- Same image with in_valid gapped (1 of every 3 cycles): identical writes and final state, no duplicate rom_we.
- Length 00 00: no rom_we; RUN entered the cycle after the length low byte; cpu_reset=0; done=1.
- Length 80 01 (32769): ERROR; error=1; cpu_reset stays 1; in_ready=0; no writes. A subsequent start plus a valid image recovers with error=0.
- start pulsed after 1 of 3 words: new length accepted. The next write targets addr 0 with the new data, and the final count matches the new N.
- reset asserted between a word's high and low bytes: next cycle IDLE with all outputs at reset values; no rom_we for the partial word.
